phase_comps_pipe: RTL and testbench

- Parametrised successor of the per-symbol phase compensator in the harden TX chain; sits between the IFFT/CP-insertion output and the DAC-side datapath.
- Multiplies each complex sample by a coefficient selected by symbol index and slot type.
- Adds configurable widths, N slot types, an in-RTL pipelined multiplier with round/saturate, and bypass.
- Adds a double-buffered coefficient table, swapped only on a frame-aligned SOP, with out-of-range detection.

---
 rtl/phase_comps_pipe.sv | 206 ++++++++++++++++++++
 tb/tb_phase_comps_pipe.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_comps_pipe.sv
// phase_comps_pipe: per-symbol complex coefficient multiply with a
// double-buffered coefficient table, round/saturate and bypass.
module phase_comps_pipe #(
  parameter int DW         = 16,
  parameter int CW         = 16,
  parameter int FRAC       = 15,
  parameter int SYM_NUM    = 14,
  parameter int SLOT_TYPES = 2,
  parameter int AW         = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            din_valid,
  input  logic            din_sop,
  input  logic            din_eop,
  input  logic [DW-1:0]   din_real,
  input  logic [DW-1:0]   din_imag,
  input  logic [3:0]      din_symbol,
  input  logic [7:0]      din_slot,
  input  logic            bypass,
  input  logic            cfg_wr_en,
  input  logic [AW-1:0]   cfg_wr_addr,
  input  logic [2*CW-1:0] cfg_wr_data,
  input  logic            cfg_commit,
  output logic            commit_pending,
  output logic            sym_err,
  output logic            dout_valid,
  output logic            dout_sop,
  output logic            dout_eop,
  output logic [DW-1:0]   dout_real,
  output logic [DW-1:0]   dout_imag
);

  localparam int DEPTH = SYM_NUM * SLOT_TYPES;
  localparam int NE    = 2 ** AW;
  localparam int PW    = DW + CW;
  localparam int SW    = DW + CW + 1;

  localparam logic [2*CW-1:0] UNITY =
    {{CW{1'b0}}, 1'b0, {(CW-1){1'b1}}};
  localparam logic [SW-1:0] RND =
    {{(SW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

  typedef struct packed {
    logic          v, sop, eop, byp;
    logic [DW-1:0] ar, ai;
    logic [CW-1:0] cr, ci;
  } s1_t;

  typedef struct packed {
    logic          v, sop, eop, byp;
    logic [DW-1:0] ar, ai;
    logic [PW-1:0] rr, ii, ri, ir;
  } s2_t;

  typedef struct packed {
    logic          v, sop, eop, byp;
    logic [DW-1:0] ar, ai;
    logic [SW-1:0] pr, pi;
  } s3_t;

  typedef struct packed {
    logic          v, sop, eop;
    logic [DW-1:0] re, im;
  } s4_t;

  logic [31:0]     set_idx;
  logic [AW-1:0]   rd_addr;
  logic            sop_v, sym_oor, swap;
  logic            act_q, act_d;
  logic            pend_q, pend_d;
  logic            err_q, err_d;
  logic [2*CW-1:0] coef_q, coef_d;
  logic [2*CW-1:0] tbl_q [2][NE];
  logic [2*CW-1:0] tbl_d [2][NE];
  s1_t             s1_q, s1_d;
  s2_t             s2_q, s2_d;
  s3_t             s3_q, s3_d;
  s4_t             s4_q, s4_d;
  logic signed [PW-1:0] ar_e, ai_e, cr_e, ci_e;

  function automatic logic [DW-1:0] sat(
    input logic signed [SW-1:0] x
  );
    logic signed [SW-1:0] s;
    logic [SW-DW:0]       hi;
    s  = x >>> FRAC;
    hi = s[SW-1:DW-1];
    if ((&hi) || (~|hi)) return s[DW-1:0];
    return s[SW-1] ? {1'b1, {(DW-1){1'b0}}}
                   : {1'b0, {(DW-1){1'b1}}};
  endfunction

  // Table lookup, bank swap, sticky error and shadow writes
  always_comb begin
    set_idx = 32'(din_slot) % SLOT_TYPES;
    rd_addr = AW'(set_idx * SYM_NUM + 32'(din_symbol));
    sop_v   = din_valid & din_sop;
    sym_oor = 32'(din_symbol) >= SYM_NUM;
    swap    = sop_v & (din_symbol == 4'd0) &
              (set_idx == 32'd0) & (pend_q | cfg_commit);
    act_d   = act_q ^ swap;
    pend_d  = swap ? 1'b0 : (pend_q | cfg_commit);
    err_d   = err_q | (sop_v & sym_oor);
    coef_d  = coef_q;
    if (sop_v)
      coef_d = sym_oor ? UNITY : tbl_q[act_d][rd_addr];
    tbl_d = tbl_q;
    if (cfg_wr_en && (32'(cfg_wr_addr) < DEPTH))
      tbl_d[~act_d][cfg_wr_addr] = cfg_wr_data;
  end

  // Datapath next-state: products, sums+round, shift/saturate
  always_comb begin
    s1_d.v   = din_valid;
    s1_d.sop = din_sop;
    s1_d.eop = din_eop;
    s1_d.byp = bypass;
    s1_d.ar  = din_real;
    s1_d.ai  = din_imag;
    s1_d.cr  = coef_d[CW-1:0];
    s1_d.ci  = coef_d[2*CW-1:CW];

    ar_e = PW'($signed(s1_q.ar));
    ai_e = PW'($signed(s1_q.ai));
    cr_e = PW'($signed(s1_q.cr));
    ci_e = PW'($signed(s1_q.ci));
    s2_d.v   = s1_q.v;
    s2_d.sop = s1_q.sop;
    s2_d.eop = s1_q.eop;
    s2_d.byp = s1_q.byp;
    s2_d.ar  = s1_q.ar;
    s2_d.ai  = s1_q.ai;
    s2_d.rr  = ar_e * cr_e;
    s2_d.ii  = ai_e * ci_e;
    s2_d.ri  = ar_e * ci_e;
    s2_d.ir  = ai_e * cr_e;

    s3_d.v   = s2_q.v;
    s3_d.sop = s2_q.sop;
    s3_d.eop = s2_q.eop;
    s3_d.byp = s2_q.byp;
    s3_d.ar  = s2_q.ar;
    s3_d.ai  = s2_q.ai;
    s3_d.pr  = SW'($signed(s2_q.rr)) -
               SW'($signed(s2_q.ii)) + RND;
    s3_d.pi  = SW'($signed(s2_q.ri)) +
               SW'($signed(s2_q.ir)) + RND;

    s4_d.v   = s3_q.v;
    s4_d.sop = s3_q.sop;
    s4_d.eop = s3_q.eop;
    s4_d.re  = s3_q.byp ? s3_q.ar : sat($signed(s3_q.pr));
    s4_d.im  = s3_q.byp ? s3_q.ai : sat($signed(s3_q.pi));
  end

  // Control state: active bank, pending commit, error, held coef
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q  <= 1'b0;
      pend_q <= 1'b0;
      err_q  <= 1'b0;
      coef_q <= UNITY;
    end else begin
      act_q  <= act_d;
      pend_q <= pend_d;
      err_q  <= err_d;
      coef_q <= coef_d;
    end
  end

  // Both coefficient banks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < NE; i++)
          tbl_q[b][i] <= '0;
    end else begin
      tbl_q <= tbl_d;
    end
  end

  // Four-stage datapath pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      s4_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      s4_q <= s4_d;
    end
  end

  assign commit_pending = pend_q;
  assign sym_err        = err_q;
  assign dout_valid     = s4_q.v;
  assign dout_sop       = s4_q.sop;
  assign dout_eop       = s4_q.eop;
  assign dout_real      = s4_q.re;
  assign dout_imag      = s4_q.im;

endmodule

// File: tb/tb_phase_comps_pipe.sv
// tb_phase_comps_pipe: scoreboard bench with a behavioural model
// of the coefficient banks, commit rule and complex multiply.
module tb_phase_comps_pipe;

  localparam int DW = 16, CW = 16, FRAC = 15;
  localparam int SYMN = 14, ST = 2, AW = 5;
  localparam logic [31:0] UNITY = 32'h0000_7fff;

  logic clk = 0, rst_n = 0;
  logic din_valid = 0, din_sop = 0, din_eop = 0;
  logic [DW-1:0] din_real = 0, din_imag = 0;
  logic [3:0] din_symbol = 0;
  logic [7:0] din_slot = 0;
  logic bypass = 0, cfg_wr_en = 0, cfg_commit = 0;
  logic [AW-1:0] cfg_wr_addr = 0;
  logic [2*CW-1:0] cfg_wr_data = 0;
  logic commit_pending, sym_err;
  logic dout_valid, dout_sop, dout_eop;
  logic [DW-1:0] dout_real, dout_imag;

  phase_comps_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .din_valid(din_valid), .din_sop(din_sop), .din_eop(din_eop),
    .din_real(din_real), .din_imag(din_imag),
    .din_symbol(din_symbol), .din_slot(din_slot),
    .bypass(bypass), .cfg_wr_en(cfg_wr_en),
    .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_commit(cfg_commit), .commit_pending(commit_pending),
    .sym_err(sym_err), .dout_valid(dout_valid),
    .dout_sop(dout_sop), .dout_eop(dout_eop),
    .dout_real(dout_real), .dout_imag(dout_imag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int re, im;
    bit sop, eop;
    int at;
  } exp_t;
  exp_t sbq[$];

  int total = 0, bad = 0;

  logic [31:0] m_tbl [2][32];
  bit m_act, m_pend, m_err;
  logic [31:0] m_coef;

  function automatic int clamp(longint p);
    longint s;
    s = (p + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return int'(s);
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 32; i++) m_tbl[b][i] = '0;
    m_act = 0; m_pend = 0; m_err = 0; m_coef = UNITY;
    sbq.delete();
  endtask

  // One cycle: drive inputs, advance model, check control outputs
  task automatic step(bit v, bit sop, bit eop, int re, int im,
                      int sym, int slot, bit byp,
                      bit we = 0, int wa = 0,
                      logic [31:0] wd = '0, bit cm = 0);
    int set;
    longint ar, ai, cr, ci;
    exp_t e;
    din_valid = v; din_sop = sop; din_eop = eop;
    din_real = 16'(re); din_imag = 16'(im);
    din_symbol = 4'(sym); din_slot = 8'(slot);
    bypass = byp; cfg_wr_en = we; cfg_wr_addr = 5'(wa);
    cfg_wr_data = wd; cfg_commit = cm;
    set = slot % ST;
    if (v && sop && sym == 0 && set == 0 && (m_pend || cm)) begin
      m_act = !m_act;
      m_pend = 0;
    end else if (cm) m_pend = 1;
    if (we && wa < SYMN * ST) m_tbl[!m_act][wa] = wd;
    if (v && sop) begin
      if (sym >= SYMN) begin
        m_coef = UNITY;
        m_err = 1;
      end else m_coef = m_tbl[m_act][set * SYMN + sym];
    end
    if (v) begin
      ar = re; ai = im;
      cr = longint'($signed(m_coef[15:0]));
      ci = longint'($signed(m_coef[31:16]));
      e.sop = sop; e.eop = eop; e.at = cyc + 4;
      if (byp) begin
        e.re = re; e.im = im;
      end else begin
        e.re = clamp(ar * cr - ai * ci);
        e.im = clamp(ar * ci + ai * cr);
      end
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    total++;
    if (sym_err !== m_err) begin
      bad++;
      $display("FAIL sym_err cyc=%0d got=%b exp=%b",
               cyc, sym_err, m_err);
    end
    total++;
    if (commit_pending !== m_pend) begin
      bad++;
      $display("FAIL commit_pending cyc=%0d got=%b exp=%b",
               cyc, commit_pending, m_pend);
    end
  endtask

  task automatic idle(int n = 1);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(int a, int im, int re);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, a, {16'(im), 16'(re)});
  endtask

  task automatic send(int re, int im, int sym, int slot,
                      bit sop, bit eop, bit byp = 0,
                      bit cm = 0);
    step(1, sop, eop, re, im, sym, slot, byp, 0, 0, '0, cm);
  endtask

  task automatic symb(int n, int re, int im, int sym, int slot);
    for (int i = 0; i < n; i++)
      send(re, im, sym, slot, i == 0, i == n - 1);
  endtask

  task automatic check_zero(string nm);
    total++;
    if ({dout_valid, dout_sop, dout_eop, dout_real, dout_imag,
         sym_err, commit_pending} !== '0) begin
      bad++;
      $display("FAIL %s got v=%b r=%0d i=%0d err=%b pend=%b exp=all0",
               nm, dout_valid, $signed(dout_real),
               $signed(dout_imag), sym_err, commit_pending);
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    din_valid = 0; din_sop = 0; din_eop = 0;
    cfg_wr_en = 0; cfg_commit = 0; bypass = 0;
    model_reset();
    #1;
    check_zero("reset_async");
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_held");
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  // Monitor: pop expected entries as outputs appear
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (dout_valid) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out cyc=%0d got=(%0d,%0d)",
                   cyc, $signed(dout_real), $signed(dout_imag));
        end else begin
          e = sbq.pop_front();
          if (int'($signed(dout_real)) != e.re ||
              int'($signed(dout_imag)) != e.im ||
              dout_sop !== e.sop || dout_eop !== e.eop ||
              cyc != e.at) begin
            bad++;
            $display({"FAIL sample cyc=%0d got=(%0d,%0d) sop=%b",
                      " eop=%b exp=(%0d,%0d) sop=%b eop=%b at=%0d"},
                     cyc, $signed(dout_real), $signed(dout_imag),
                     dout_sop, dout_eop, e.re, e.im, e.sop, e.eop,
                     e.at);
          end
        end
      end else if (sbq.size() != 0 && sbq[0].at <= cyc) begin
        total++;
        bad++;
        e = sbq.pop_front();
        $display("FAIL missing_out cyc=%0d got=none exp=(%0d,%0d)",
                 cyc, e.re, e.im);
      end
    end
  end

  initial begin
    int rem, rsym, rslot, rbyp;
    model_reset();
    do_reset();
    check_zero("after_reset");

    // valid sample with no SOP since reset: unity coefficient
    send(100, 200, 5, 1, 0, 0);
    send(-300, 7, 5, 1, 0, 0);
    idle(2);

    // latency / unity
    wr(0, 0, 32767);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0, 1);
    symb(4, 16384, 0, 0, 0);
    idle(2);

    // populate the other bank and swap to it
    wr(0, 0, 32767);
    wr(14, 0, 32767);
    wr(1, 0, -32768);
    wr(2, -32768, -32768);
    wr(3, 0, 16384);
    wr(17, 32767, 0);
    wr(31, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0, 1);
    symb(1, 5, 5, 0, 0);

    // rotation by j
    send(16384, 0, 3, 1, 1, 0);
    send(0, 1000, 3, 1, 0, 1);
    // saturation
    symb(1, -32768, -32768, 2, 0);
    symb(1, -32768, 0, 1, 0);
    // rounding
    symb(1, 3, -3, 3, 0);
    symb(1, -3, 3, 3, 2);
    idle(2);

    // commit timing: shadow addr0 halved, commit during slot 1
    wr(0, 0, 16384);
    send(1000, -2000, 0, 1, 1, 0, 0, 1);
    send(1000, -2000, 0, 1, 0, 1);
    symb(2, 1000, -2000, 0, 2);
    idle(1);

    // bypass, including a mid-symbol toggle
    send(1234, -5678, 3, 0, 1, 0, 1);
    send(1234, -5678, 3, 0, 0, 0, 0);
    send(-32768, 32767, 3, 0, 0, 1, 1);
    // out-of-range symbol
    symb(2, 1000, -7, 14, 0);
    idle(5);

    // randomized traffic with writes and commits
    rem = 0; rsym = 0; rslot = 0; rbyp = 0;
    for (int i = 0; i < 600; i++) begin
      bit v, sp, ep, we, cm;
      v = 0; sp = 0; ep = 0;
      we = ($urandom_range(0, 3) == 0);
      cm = ($urandom_range(0, 19) == 0);
      if (rem == 0 && $urandom_range(0, 2) != 0) begin
        rem = $urandom_range(1, 6);
        rsym = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15)
                                            : $urandom_range(0, 2);
        rslot = $urandom_range(0, 3);
        sp = 1;
      end
      if (rem != 0 && (sp || $urandom_range(0, 4) != 0)) begin
        v = 1;
        ep = (rem == 1);
        rem--;
        rbyp = ($urandom_range(0, 5) == 0);
      end
      step(v, sp, ep,
           int'($urandom_range(0, 65535)) - 32768,
           int'($urandom_range(0, 65535)) - 32768,
           rsym, rslot, 1'(rbyp), we, $urandom_range(0, 31),
           $urandom, cm);
    end
    idle(6);

    // reset while samples are in flight
    wr(0, 0, 32767);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0, 1);
    symb(3, 500, 600, 0, 0);
    send(700, 800, 0, 0, 1, 0);
    do_reset();
    check_zero("mid_reset_flush");
    send(-100, 50, 0, 0, 1, 1);
    idle(6);

    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d left exp=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
